// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver
// 2-flop input synchroniser, 3-sample majority vote, parity/framing/break/overrun flags.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 brk,
  output logic                 overrun
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_V0  = TW'(M - 1);
  localparam logic [TW-1:0] T_V1  = TW'(M);
  localparam logic [TW-1:0] T_V2  = TW'(M + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 sync1, sync2, rxs;
  logic [2:0]           state;
  logic [TW-1:0]        tick;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 v0, v1, vote;
  logic [DATA_BITS-1:0] scratch;
  logic                 par_bad, par_low, fe_acc, first_stop_low;
  logic                 mid, bit_end, last_stop, done, first_low_now;

  assign rxs           = sync2;
  assign vote          = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign mid           = (tick == T_V2);
  assign bit_end       = (tick == T_END);
  assign last_stop     = (STOP_BITS == 1) || stop_cnt;
  assign done          = clken && (state == S_STOP) && mid && last_stop;
  assign first_low_now = stop_cnt ? first_stop_low : !vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      tick           <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      v0             <= 1'b0;
      v1             <= 1'b0;
      scratch        <= '0;
      par_bad        <= 1'b0;
      par_low        <= 1'b0;
      fe_acc         <= 1'b0;
      first_stop_low <= 1'b0;
    end else if (clken) begin
      if (state != S_IDLE) begin
        tick <= bit_end ? '0 : tick + 1'b1;
        if (tick == T_V0) v0 <= rxs;
        if (tick == T_V1) v1 <= rxs;
      end
      case (state)
        S_IDLE: begin
          // The detecting tick is tick 0 of the start bit.
          if (!rxs) begin
            state          <= S_START;
            tick           <= TW'(1);
            fe_acc         <= 1'b0;
            first_stop_low <= 1'b0;
            par_bad        <= 1'b0;
            par_low        <= 1'b0;
          end
        end
        S_START: begin
          if (mid && vote) begin
            state <= S_IDLE;
            tick  <= '0;
          end else if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (mid) scratch <= {vote, scratch[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (mid) begin
            par_low <= !vote;
            par_bad <= (PARITY == 1) ? !((^scratch) ^ vote) : ((^scratch) ^ vote);
          end
          if (bit_end) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          // Completion on the last stop bit's vote tick, not at end of bit.
          if (mid) begin
            if (!vote) fe_acc <= 1'b1;
            if (!stop_cnt) first_stop_low <= !vote;
            if (last_stop) begin
              state <= S_IDLE;
              tick  <= '0;
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy        <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      // Set beats a coincident clear; overrun looks at the pre-edge rdy.
      if (done) begin
        data       <= scratch;
        parity_err <= (PARITY != 0) && par_bad;
        frame_err  <= fe_acc | !vote;
        brk        <= (scratch == '0) && ((PARITY == 0) || par_low) && first_low_now;
        rdy        <= 1'b1;
        if (rdy) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic clk = 1'b0;
  logic rst, clken, rdy_clr, rx_a, rx_b;
  logic rdy_a, pe_a, fe_a, brk_a, ov_a;
  logic rdy_b, pe_b, fe_b, brk_b, ov_b;
  logic [7:0] data_a, data_b;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe, fe, bk, ov;
    int         tk;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic prev_rdy_a = 1'b0, prev_ov_a = 1'b0, prev_rdy_b = 1'b0, prev_ov_b = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .clken(clken), .rx(rx_a), .rdy_clr(rdy_clr),
    .rdy(rdy_a), .data(data_a), .parity_err(pe_a), .frame_err(fe_a), .brk(brk_a), .overrun(ov_a)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .clken(clken), .rx(rx_b), .rdy_clr(rdy_clr),
    .rdy(rdy_b), .data(data_b), .parity_err(pe_b), .frame_err(fe_b), .brk(brk_b), .overrun(ov_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One oversample tick = two clk cycles; clken, rdy_clr and rst pulse on the first edge.
  task automatic do_tick(input logic v, input int sel, input logic clr, input logic rs);
    tick_no++;
    if (sel == 0) rx_a = v; else rx_b = v;
    rdy_clr = clr;
    rst     = rs;
    clken   = 1'b1;
    @(posedge clk);
    #1;
    clken   = 1'b0;
    rdy_clr = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // The DUT sees bench tick i one tick later, so completion lands on stop tick M+2.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit pen, input bit pbit,
                            input bit stopv, input bit glitch, input bit clr_done, input int rst_at);
    int o;
    logic v;
    o = 0;
    for (int t = 0; t < OS; t++) begin do_tick(1'b0, sel, 1'b0, o == rst_at); o++; end
    for (int k = 0; k < 8; k++)
      for (int t = 0; t < OS; t++) begin
        v = d[k];
        if (glitch && k == 0 && t == M) v = 1'b1;
        do_tick(v, sel, 1'b0, o == rst_at);
        o++;
      end
    if (pen)
      for (int t = 0; t < OS; t++) begin do_tick(pbit, sel, 1'b0, o == rst_at); o++; end
    for (int t = 0; t < OS; t++) begin
      v = (t <= M + 1) ? stopv : 1'b1;
      do_tick(v, sel, clr_done && (t == M + 2), o == rst_at);
      o++;
    end
    repeat (4) do_tick(1'b1, sel, 1'b0, 1'b0);
  endtask

  task automatic push_a(input logic [7:0] d, input logic pe, input logic fe, input logic bk, input logic ov);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bk = bk; e.ov = ov;
    e.tk = tick_no + 1 + 154;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input logic pe, input logic fe, input logic bk, input logic ov);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bk = bk; e.ov = ov;
    e.tk = tick_no + 1 + 170;
    q_b.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((rdy_a && !prev_rdy_a) || (ov_a && !prev_ov_a))) begin
      if (q_a.size() == 0) chk("a_unexpected_frame", {24'h0, data_a}, 32'hffff_ffff);
      else begin
        e = q_a.pop_front();
        chk("a_data", data_a, e.d);
        chk("a_parity_err", pe_a, e.pe);
        chk("a_frame_err", fe_a, e.fe);
        chk("a_brk", brk_a, e.bk);
        chk("a_overrun", ov_a, e.ov);
        chk("a_rdy", rdy_a, 1);
        chk("a_done_tick", tick_no, e.tk);
      end
    end
    prev_rdy_a <= rdy_a;
    prev_ov_a  <= ov_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((rdy_b && !prev_rdy_b) || (ov_b && !prev_ov_b))) begin
      if (q_b.size() == 0) chk("b_unexpected_frame", {24'h0, data_b}, 32'hffff_ffff);
      else begin
        e = q_b.pop_front();
        chk("b_data", data_b, e.d);
        chk("b_parity_err", pe_b, e.pe);
        chk("b_frame_err", fe_b, e.fe);
        chk("b_brk", brk_b, e.bk);
        chk("b_overrun", ov_b, e.ov);
        chk("b_done_tick", tick_no, e.tk);
      end
    end
    prev_rdy_b <= rdy_b;
    prev_ov_b  <= ov_b;
  end

  initial begin
    rst = 1'b1; clken = 1'b0; rdy_clr = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rdy", rdy_a, 0);
    chk("reset_data", data_a, 0);
    chk("reset_overrun", ov_a, 0);
    chk("reset_parity_err", pe_a, 0);
    chk("reset_frame_err", fe_a, 0);
    chk("reset_brk", brk_a, 0);
    chk("reset_rdy_b", rdy_b, 0);
    rst = 1'b0;
    repeat (5) do_tick(1'b1, 0, 1'b0, 1'b0);

    // 8N1 0xA5, then clear
    push_a(8'hA5, 0, 0, 0, 0);
    send_frame(0, 8'hA5, 0, 0, 1, 0, 0, -1);
    do_tick(1'b1, 0, 1'b1, 1'b0);
    chk("rdy_after_clr", rdy_a, 0);

    // 4-tick glitch is a false start, then a valid 0x3C
    repeat (4) do_tick(1'b0, 0, 1'b0, 1'b0);
    repeat (30) do_tick(1'b1, 0, 1'b0, 1'b0);
    chk("glitch_no_rdy", rdy_a, 0);
    push_a(8'h3C, 0, 0, 0, 0);
    send_frame(0, 8'h3C, 0, 0, 1, 0, 0, -1);
    do_tick(1'b1, 0, 1'b1, 1'b0);

    // 8E1: 0x03 has even data parity; parity bit 1 is wrong, 0 is right
    push_b(8'h03, 1, 0, 0, 0);
    send_frame(1, 8'h03, 1, 1, 1, 0, 0, -1);
    do_tick(1'b1, 1, 1'b1, 1'b0);
    push_b(8'h03, 0, 0, 0, 0);
    send_frame(1, 8'h03, 1, 0, 1, 0, 0, -1);
    do_tick(1'b1, 1, 1'b1, 1'b0);

    // 0x00 with a one-tick spike on the centre vote, stop low: break
    push_a(8'h00, 0, 1, 1, 0);
    send_frame(0, 8'h00, 0, 0, 0, 1, 0, -1);
    do_tick(1'b1, 0, 1'b1, 1'b0);

    // Overrun without clear, then with clear coincident on completion
    push_a(8'h11, 0, 0, 0, 0);
    send_frame(0, 8'h11, 0, 0, 1, 0, 0, -1);
    push_a(8'h22, 0, 0, 0, 1);
    send_frame(0, 8'h22, 0, 0, 1, 0, 0, -1);
    do_tick(1'b1, 0, 1'b1, 1'b0);
    push_a(8'h33, 0, 0, 0, 0);
    send_frame(0, 8'h33, 0, 0, 1, 0, 0, -1);
    push_a(8'h44, 0, 0, 0, 1);
    send_frame(0, 8'h44, 0, 0, 1, 0, 1, -1);
    chk("set_wins_rdy", rdy_a, 1);
    chk("set_wins_overrun", ov_a, 1);

    // Reset at tick 60 of a frame, then a clean 0x5A
    send_frame(0, 8'hFF, 0, 0, 1, 0, 0, 60);
    chk("midreset_rdy", rdy_a, 0);
    chk("midreset_data", data_a, 0);
    chk("midreset_overrun", ov_a, 0);
    chk("midreset_frame_err", fe_a, 0);
    chk("midreset_parity_err", pe_a, 0);
    chk("midreset_brk", brk_a, 0);
    push_a(8'h5A, 0, 0, 0, 0);
    send_frame(0, 8'h5A, 0, 0, 1, 0, 0, -1);

    repeat (20) do_tick(1'b1, 0, 1'b0, 1'b0);
    chk("a_frames_outstanding", q_a.size(), 0);
    chk("b_frames_outstanding", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
